// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller, its bit sampler and the
// configuration source. The master side drives the line and configuration.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic                  dat_samp_en;
    logic [5:0]            edge_cnt;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  strt_glitch;

    modport master (
        output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );

    modport slave (
        input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
        output dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Frame sequencer for an oversampled UART receiver: paces the external bit
// sampler, assembles the word and reports parity/stop/start-glitch errors.
//   state  | meaning
//   IDLE   | line idle, waiting for RX_IN low with a legal prescale
//   START  | start bit
//   DATA   | data bits, LSB first; first cycle checks the start bit
//   PARITY | parity bit, only when PAR_EN was latched
//   STOP   | stop bit; first cycle checks parity
//   DONE   | stop bit evaluated, status registered for next cycle
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [5:0]            presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [5:0]            edge_q;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  strt_chk;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;
    logic                  sg_q;

    logic presc_ok;
    logic start_req;
    logic bit_end;
    logic glitch;
    logic capture;

    function automatic logic in_frame(input logic [2:0] s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

    always_comb begin
        presc_ok = 1'b0;
        case (bus.prescale)
            6'd2, 6'd4, 6'd8, 6'd16, 6'd32: presc_ok = 1'b1;
            default:                        presc_ok = 1'b0;
        endcase
    end

    assign start_req = !bus.RX_IN && presc_ok;
    assign bit_end   = (edge_q == presc_q - 6'd1);
    assign glitch    = (state == DATA) && strt_chk && bus.sampled_bit;
    // Capture cycle of the previous data bit: first cycle of the following bit.
    assign capture   = (edge_q == 6'd0) &&
                       (((state == DATA) && !strt_chk) || (state == PARITY) ||
                        ((state == STOP) && !par_en_q));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_req) state_nxt = START;
            START:  if (bit_end) state_nxt = DATA;
            DATA: begin
                if (glitch)
                    state_nxt = IDLE;
                else if (bit_end && (bit_cnt == LAST_BIT))
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP:   if (bit_end) state_nxt = DONE;
            DONE:   state_nxt = start_req ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            edge_q    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            strt_chk  <= 1'b0;
            par_bad   <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            sg_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            strt_chk <= (state == START) && bit_end;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
            sg_q     <= glitch;

            if (in_frame(state) && in_frame(state_nxt))
                edge_q <= bit_end ? 6'd0 : edge_q + 6'd1;
            else
                edge_q <= 6'd0;

            if ((state_nxt == START) && !in_frame(state)) begin
                presc_q   <= bus.prescale;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                bit_cnt   <= '0;
                par_bad   <= 1'b0;
            end

            if ((state == DATA) && bit_end && (bit_cnt != LAST_BIT))
                bit_cnt <= bit_cnt + 4'd1;

            if (capture)
                shreg <= {bus.sampled_bit, shreg[DATA_WIDTH-1:1]};

            if ((state == STOP) && (edge_q == 6'd0) && par_en_q)
                par_bad <= (bus.sampled_bit != ((^shreg) ^ par_typ_q));

            if (state == DONE) begin
                pe_q <= par_bad;
                se_q <= !bus.sampled_bit;
                if (!par_bad && bus.sampled_bit) begin
                    dv_q     <= 1'b1;
                    p_data_q <= shreg;
                end
            end
        end
    end

    assign bus.dat_samp_en = in_frame(state);
    assign bus.edge_cnt    = edge_q;
    assign bus.P_DATA      = p_data_q;
    assign bus.data_valid  = dv_q;
    assign bus.par_err     = pe_q;
    assign bus.stp_err     = se_q;
    assign bus.strt_glitch = sg_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a per-cycle stimulus/expectation schedule is planned
// from frame-level timing arithmetic, then replayed and compared every cycle.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int N  = 16384;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    bit          rx_s [N];
    bit          sb_s [N];
    bit          pen_s[N];
    bit          pty_s[N];
    bit          rst_s[N];
    logic [5:0]  ps_s [N];

    bit          e_en [N];
    bit          e_dv [N];
    bit          e_pe [N];
    bit          e_se [N];
    bit          e_sg [N];
    bit          e_ld [N];
    bit          e_clr[N];
    logic [5:0]  e_ec [N];
    logic [DW-1:0] e_pd[N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int end_cyc;
    int t36, t37, t38, t39, t40, t41, t_ill;

    function automatic logic [5:0] illegal_ps();
        logic [5:0] v;
        do v = 6'($urandom); while (v inside {6'd2, 6'd4, 6'd8, 6'd16, 6'd32});
        return v;
    endfunction

    // Frame whose START occupies cycle t. START + DW data + optional parity +
    // STOP each last p cycles; DONE follows; status is visible one cycle later.
    // Returns the first cycle after DONE (or after the glitch abort).
    function automatic int plan_frame(int t, int p, bit pen, bit ptyp, logic [DW-1:0] d,
                                      bit pbit, bit sbit, bit glitch, bit noise, int cut);
        int len  = (2 + DW + (pen ? 1 : 0)) * p;
        int span = glitch ? p + 1 : len;
        bit pe, se;
        rx_s[t-1] = 1'b0;
        ps_s[t-1] = 6'(p);
        pen_s[t-1] = pen;
        pty_s[t-1] = ptyp;
        for (int n = 0; n < span; n++) begin
            if (t + n < cut) begin
                e_en[t+n] = 1'b1;
                e_ec[t+n] = 6'(n % p);
                rx_s[t+n] = noise ? 1'($urandom) : 1'b1;
            end
        end
        sb_s[t+p] = glitch;
        if (glitch) begin
            if (t + p + 1 < cut) e_sg[t+p+1] = 1'b1;
            return t + p + 1;
        end
        for (int k = 0; k < DW; k++) sb_s[t + (k + 2) * p] = d[k];
        if (pen) sb_s[t + (DW + 2) * p] = pbit;
        sb_s[t+len] = sbit;
        rx_s[t+len] = 1'b1;
        pe = pen && (pbit != ((^d) ^ ptyp));
        se = !sbit;
        if (t + len + 1 < cut) begin
            e_pe[t+len+1] = pe;
            e_se[t+len+1] = se;
            e_dv[t+len+1] = !pe && !se;
            e_ld[t+len+1] = !pe && !se;
            e_pd[t+len+1] = d;
        end
        return t + len + 1;
    endfunction

    task automatic apply(input int c);
        RST             = rst_s[c];
        bus.RX_IN       = rx_s[c];
        bus.prescale    = ps_s[c];
        bus.PAR_EN      = pen_s[c];
        bus.PAR_TYP     = pty_s[c];
        bus.sampled_bit = sb_s[c];
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        int t, r, p, nfr, nill;
        bit pen, pty, sbit, pbit, gl, b2b;
        logic [DW-1:0] d;
        for (int c = 0; c < N; c++) begin
            rx_s[c] = 1'b1;  sb_s[c] = 1'($urandom);
            ps_s[c] = 6'($urandom);  pen_s[c] = 1'($urandom);  pty_s[c] = 1'($urandom);
            rst_s[c] = 1'b0;
            e_en[c] = 0; e_dv[c] = 0; e_pe[c] = 0; e_se[c] = 0; e_sg[c] = 0;
            e_ld[c] = 0; e_clr[c] = 0; e_ec[c] = '0; e_pd[c] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            rst_s[c] = 1'b1;
            e_clr[c+1] = 1'b1;
        end

        t = 8;
        t36 = t;  r = plan_frame(t, 8, 1, 0, 8'hA5, 0, 1, 0, 0, N);
        t = r + 3;  t37 = t;  r = plan_frame(t, 8, 1, 0, 8'hA5, 1, 1, 0, 0, N);
        t = r + 3;  t38 = t;  r = plan_frame(t, 4, 0, 0, 8'h3C, 0, 0, 0, 0, N);
        t = r + 3;  t39 = t;  r = plan_frame(t, 16, 0, 0, 8'h00, 0, 1, 1, 0, N);
        rx_s[t] = 1'b0;  rx_s[t+1] = 1'b0;
        t = r + 3;  t40 = t;  r = plan_frame(t, 8, 0, 0, 8'h55, 0, 1, 0, 0, N);
        t = r;      r = plan_frame(t, 8, 0, 0, 8'hAA, 0, 1, 0, 0, N);
        t = r + 3;  t41 = t;  r = plan_frame(t, 8, 1, 0, 8'h96, 0, 1, 0, 1, t + 21);
        rst_s[t+20] = 1'b1;  e_clr[t+21] = 1'b1;
        t_ill = t + 23;
        for (int c = t_ill; c < t_ill + 12; c++) begin
            rx_s[c] = 1'b0;  ps_s[c] = 6'd5;
        end

        t = t_ill + 15;  nfr = 0;  b2b = 1'b0;
        while (t < N - 700 && nfr < 60) begin
            if (!b2b) begin
                nill = $urandom_range(0, 3);
                for (int k = 0; k < nill; k++) begin
                    rx_s[t-1+k] = 1'b0;  ps_s[t-1+k] = illegal_ps();
                end
                t += nill;
            end
            p    = 2 << $urandom_range(0, 4);
            pen  = 1'($urandom);  pty = 1'($urandom);  d = DW'($urandom);
            pbit = (^d) ^ pty ^ ($urandom_range(0, 3) == 0);
            sbit = ($urandom_range(0, 3) != 0);
            gl   = ($urandom_range(0, 7) == 0);
            r    = plan_frame(t, p, pen, pty, d, pbit, sbit, gl, 1, N);
            b2b  = !gl && ($urandom_range(0, 3) == 0);
            t    = b2b ? r : r + 1 + $urandom_range(0, 3);
            nfr++;
        end
        end_cyc = t + 20;

        apply(0);
        while (cyc < end_cyc) begin
            @(posedge CLK);
            cyc++;
            #1 apply(cyc);
        end
        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [DW-1:0] m_pd;
        m_pd = '0;
        forever begin
            @(negedge CLK);
            if (cyc >= 1 && cyc < N) begin
                if (e_clr[cyc]) m_pd = '0;
                if (e_ld[cyc])  m_pd = e_pd[cyc];
                chk("dat_samp_en", int'(bus.dat_samp_en), int'(e_en[cyc]));
                chk("edge_cnt",    int'(bus.edge_cnt),    int'(e_ec[cyc]));
                chk("data_valid",  int'(bus.data_valid),  int'(e_dv[cyc]));
                chk("par_err",     int'(bus.par_err),     int'(e_pe[cyc]));
                chk("stp_err",     int'(bus.stp_err),     int'(e_se[cyc]));
                chk("strt_glitch", int'(bus.strt_glitch), int'(e_sg[cyc]));
                chk("P_DATA",      int'(bus.P_DATA),      int'(m_pd));

                if (cyc == t36 + 87) begin
                    chk("a5_stop_en", int'(bus.dat_samp_en), 1);
                    chk("a5_stop_ec", int'(bus.edge_cnt), 7);
                end
                if (cyc == t36 + 88) begin
                    chk("a5_done_en", int'(bus.dat_samp_en), 0);
                    chk("a5_done_dv", int'(bus.data_valid), 0);
                end
                if (cyc == t36 + 89) begin
                    chk("a5_dv", int'(bus.data_valid), 1);
                    chk("a5_pd", int'(bus.P_DATA), 'hA5);
                    chk("a5_pe", int'(bus.par_err), 0);
                    chk("a5_se", int'(bus.stp_err), 0);
                end
                if (cyc == t37 + 89) begin
                    chk("par_bad_pe", int'(bus.par_err), 1);
                    chk("par_bad_dv", int'(bus.data_valid), 0);
                    chk("par_bad_pd", int'(bus.P_DATA), 'hA5);
                end
                if (cyc == t38 + 41) begin
                    chk("stop_bad_se", int'(bus.stp_err), 1);
                    chk("stop_bad_dv", int'(bus.data_valid), 0);
                    chk("stop_bad_pd", int'(bus.P_DATA), 'hA5);
                end
                if (cyc == t39 + 1) chk("p16_ec1", int'(bus.edge_cnt), 1);
                if (cyc == t39 + 17) begin
                    chk("glitch_sg", int'(bus.strt_glitch), 1);
                    chk("glitch_en", int'(bus.dat_samp_en), 0);
                    chk("glitch_ec", int'(bus.edge_cnt), 0);
                end
                if (cyc == t40 + 81) begin
                    chk("b2b_dv1", int'(bus.data_valid), 1);
                    chk("b2b_pd1", int'(bus.P_DATA), 'h55);
                    chk("b2b_start_en", int'(bus.dat_samp_en), 1);
                    chk("b2b_start_ec", int'(bus.edge_cnt), 0);
                end
                if (cyc == t40 + 162) begin
                    chk("b2b_dv2", int'(bus.data_valid), 1);
                    chk("b2b_pd2", int'(bus.P_DATA), 'hAA);
                end
                if (cyc == t41 + 21) begin
                    chk("rst_en", int'(bus.dat_samp_en), 0);
                    chk("rst_ec", int'(bus.edge_cnt), 0);
                    chk("rst_pd", int'(bus.P_DATA), 0);
                end
                if (cyc == t_ill + 11) chk("illegal_ps_en", int'(bus.dat_samp_en), 0);
            end
        end
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: RX_IN  input  1  raw serial line; idle high.
REQ-005 SHALL have port: prescale  input  6  oversampling ratio; legal values 2, 4, 8, 16, 32.
REQ-006 SHALL have port: PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: sampled_bit  input  1  bit decision from the data-sampling block.
REQ-009 SHALL have port: dat_samp_en  output  1  enable to the data-sampling block.
REQ-010 SHALL have port: edge_cnt  output  6  oversample edge index within the current bit, to the sampler.
REQ-011 SHALL have port: P_DATA  output  DATA_WIDTH  last good frame, LSB received first.
REQ-012 SHALL have port: data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-013 SHALL have port: par_err  output  1  one-cycle pulse on parity mismatch.
REQ-014 SHALL have port: stp_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
REQ-015 SHALL have port: strt_glitch  output  1  one-cycle pulse when the start bit is sampled as 1.

Function
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-017 SHALL move IDLE->START on a cycle where RX_IN==0 and prescale is legal; an illegal prescale keeps the FSM in IDLE.
REQ-018 SHALL latch prescale, PAR_EN and PAR_TYP on entry to START and use the latched values for the whole frame.
REQ-019 SHALL, on START entry, hold edge_cnt=0 in the first START cycle, then increment it by 1 per cycle.
REQ-020 SHALL wrap edge_cnt from P-1 to 0, where P is the latched prescale.
REQ-021 SHALL define the bit-end as the cycle with edge_cnt==P-1.
REQ-022 SHALL make each state except IDLE and DONE last exactly P cycles, starting at edge_cnt==0.
REQ-023 SHALL drive dat_samp_en=1 in START, DATA, PARITY and STOP, and 0 in IDLE and DONE.
REQ-024 SHALL hold edge_cnt=0 in IDLE and DONE.
REQ-025 SHALL treat sampled_bit as valid for a bit in the cycle after that bit's bit-end (the capture cycle).
REQ-026 SHALL sequence states at bit-end as follows:
- START -> DATA.
- DATA -> DATA until DATA_WIDTH bits are done.
- DATA -> PARITY if PAR_EN, else -> STOP.
- PARITY -> STOP.
- STOP -> DONE.
REQ-027 SHALL, in the start bit's capture cycle (first DATA cycle), abort to IDLE if sampled_bit==1 and pulse strt_glitch; no other output changes.
REQ-028 SHALL shift each data bit into an internal shift register on its capture cycle, LSB first, with a 4-bit bit counter.
- The counter is 0..DATA_WIDTH-1, clears on START entry and is never compared beyond DATA_WIDTH-1.
REQ-029 SHALL compute the expected parity as XOR of the data bits (even) or its inverse (odd).
- Parity is compared with sampled_bit in the parity capture cycle (first STOP cycle); the result is held until DONE.
REQ-030 SHALL evaluate the stop bit as sampled_bit in the DONE cycle.
REQ-031 SHALL register data_valid, par_err and stp_err, asserting them one cycle after DONE.
- data_valid=1 only if neither error occurs.
- P_DATA loads from the shift register only with data_valid.
- Both errors may pulse together.
- On error, P_DATA keeps its previous value.
REQ-032 SHALL go DONE->START if RX_IN==0 in the DONE cycle (back-to-back frame), else DONE->IDLE.
REQ-033 SHALL keep every status output 0 except for its single-cycle pulse.

Reset
REQ-034 SHALL, while RST==1 at a clock edge, force state IDLE and set these to 0: edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch, bit counter, shift register and latched configuration.
REQ-035 SHALL abandon a frame on reset asserted mid-frame with no status pulse, and require a fresh falling RX_IN after release.

Verification
REQ-036 SHALL verify: P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1, START entered at cycle T -> DONE at T+88, data_valid=1 and P_DATA=0xA5 at T+89, no errors.
REQ-037 SHALL verify: same frame with parity bit 1 -> par_err=1 at T+89, data_valid=0, P_DATA unchanged.
REQ-038 SHALL verify: P=4, PAR_EN=0, frame 0x3C, stop bit 0 -> stp_err=1 at T+41, data_valid=0.
REQ-039 SHALL verify: P=16, RX_IN low for 3 cycles then high (sampled_bit=1 at start capture) -> strt_glitch pulse, FSM in IDLE, dat_samp_en=0.
REQ-040 SHALL verify: two back-to-back frames 0x55 then 0xAA (P=8, PAR_EN=0) with RX_IN low in the DONE cycle -> DONE->START directly, two data_valid pulses 81 cycles apart.
REQ-041 SHALL verify: RST=1 in DATA cycle 20 -> next cycle all outputs 0 and IDLE; prescale=5 with RX_IN=0 -> FSM remains IDLE.
